sha256_msg_schedule: RTL and testbench
======================================

# sha256_msg_schedule

Upstream message-schedule stage of the SHA-256 datapath. Accepts one 512-bit message block as sixteen 32-bit big-endian words over a valid/ready handshake. Emits the 64-word schedule W[0..63], one word per cycle, each tagged with its round index, to the round-iteration stage. Holds only a 16-word sliding window, so the round stage never needs the full 64-entry array.

## Interface
- ROUNDS, 64, schedule length per block; fixed at 64 for SHA-256.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- word_in  in  32  message word; word 0 of the block first
- first_in  in  1  sampled with word 0 only: block is the first of a new message
- word_valid  in  1  word_in/first_in valid
- word_ready  out  1  stage accepts word_in this cycle
- w_out  out  32  schedule word W[t]
- w_round  out  7  t, 0..63
- first_out  out  1  copy of first_in for the block, held for all 64 words
- w_valid  out  1  w_out/w_round/first_out valid
- w_ready  in  1  downstream accepts w_out this cycle
- block_done  out  1  one-cycle pulse after W[63] is accepted

## Operation
- Registered output slot (w_out, w_round, first_out, w_valid). The slot may load when `free = !w_valid || w_ready`.
- State LOAD, t = 0..15:
  - word_ready = free, combinational.
  - On word_valid && word_ready:
    - buf[t[3:0]] <= word_in
    - w_out <= word_in, w_round <= t, w_valid <= 1
    - if t==0, latch first_in into first_out
    - t++
  - Accepting t=15 moves to EXPAND with t=16.
- State EXPAND, t = 16..63:
  - word_ready = 0.
  - When free, compute:
    - W = σ1(buf[(t-2)&15]) + buf[(t-7)&15] + σ0(buf[(t-15)&15]) + buf[t&15]
    - All adds are mod 2^32; the last term is W[t-16].
  - Then buf[t&15] <= W, w_out <= W, w_round <= t, w_valid <= 1, t++.
  - Issuing t=63 returns to LOAD with t=0.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- When free and nothing new is loaded (LOAD with no word_valid), w_valid <= 0.
- block_done <= w_valid && w_ready && (w_round == 63). Otherwise 0.
- buf is not reset. Its contents are always fully rewritten by LOAD before use.

## Timing
- Reset values:
  - w_valid = 0, w_out = 0, w_round = 0, first_out = 0, block_done = 0
  - state = LOAD, t = 0
  - word_ready = 1 in the cycle after reset.
- Latency: a word accepted at edge N is on w_out after edge N. An expanded word is issued one edge after the slot is free.
- Throughput: 1 word/cycle with w_ready held high. A block takes 64 cycles if word_valid is continuous.
- Back-to-back blocks: word 0 of the next block can be accepted in the cycle after W[63] is issued. There are no bubbles.
- Stall: while w_valid && !w_ready, w_out, w_round and first_out hold stable. Neither t nor buf advances.
- Gaps in word_valid during LOAD insert bubbles (w_valid=0). Round indices stay contiguous.
- word_valid during EXPAND is not consumed. The word must be held until word_ready.
- rst mid-block (any state): the next edge applies reset values. The partial block is discarded and the next accepted word is word 0.
- rst and word_valid in the same cycle: reset wins and the word is not accepted.

## Test plan
- Reset: assert rst 2 cycles with word_valid=1 -> w_valid=0, w_out=0, block_done=0, no word consumed; word_ready=1 after release.
- "abc" block with w_ready=1:
  - Stimulus: W0=0x61626380, W1..W14=0, W15=0x00000018, first_in=1.
  - Required: w_round 0..63 on 64 consecutive cycles; W[0..15] equal the inputs; W16=0x61626380; W17=0x000F0000.
  - All 64 words match the reference model; first_out=1 throughout; one block_done pulse after W63.
- Random w_ready backpressure (~50%) on the same block -> identical word sequence; outputs stable in every stalled cycle; word_ready=0 throughout EXPAND.
- Random word_valid gaps during LOAD, with word_valid held high during EXPAND -> no word consumed until the cycle after W63 is issued; rounds contiguous; correct schedule.
- Two random blocks back-to-back, first_in=1 then 0 -> second block's word 0 accepted the cycle after W63 is issued; first_out switches 1->0 at round 0 of block 2; both schedules match the model.
- rst asserted at w_round=40 -> w_valid=0 next cycle; a following "abc" block yields the correct schedule from W0.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: accepts 16 message words, emits W[0..63] one per cycle
// from a 16-word sliding window, with a registered valid/ready output slot.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        first_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [31:0] w_out,
  output logic [6:0]  w_round,
  output logic        first_out,
  output logic        w_valid,
  input  logic        w_ready,
  output logic        block_done
);

  localparam logic [6:0] LAST = 7'(ROUNDS - 1);

  typedef enum logic {LOAD, EXPAND} state_t;

  state_t      state, state_nx;
  logic [6:0]  t;
  logic [31:0] wbuf [16];
  logic        free, load, expand;
  logic [31:0] w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign free = !w_valid || w_ready;

  // 4-bit window indices wrap mod 16; t-15 lands on t+1, and wbuf[t] still holds W[t-16]
  assign w_new = sig1(wbuf[t[3:0] - 4'd2]) + wbuf[t[3:0] - 4'd7]
               + sig0(wbuf[t[3:0] - 4'd15]) + wbuf[t[3:0]];

  always_comb begin
    state_nx   = state;
    word_ready = 1'b0;
    load       = 1'b0;
    expand     = 1'b0;
    case (state)
      LOAD: begin
        word_ready = free && !rst;
        load       = word_valid && word_ready;
        if (load && t == 7'd15) state_nx = EXPAND;
      end
      EXPAND: begin
        expand = free;
        if (free && t == LAST) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // Window storage needs no reset: LOAD rewrites all 16 entries before EXPAND reads them.
  always_ff @(posedge clk) begin
    if (load)                wbuf[t[3:0]] <= word_in;
    else if (expand && !rst) wbuf[t[3:0]] <= w_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      t          <= '0;
      w_out      <= '0;
      w_round    <= '0;
      first_out  <= 1'b0;
      w_valid    <= 1'b0;
      block_done <= 1'b0;
    end else begin
      state      <= state_nx;
      block_done <= w_valid && w_ready && (w_round == LAST);
      if (load) begin
        w_out   <= word_in;
        w_round <= t;
        w_valid <= 1'b1;
        if (t == 7'd0) first_out <= first_in;
        t       <= t + 7'd1;
      end else if (expand) begin
        w_out   <= w_new;
        w_round <= t;
        w_valid <= 1'b1;
        t       <= (t == LAST) ? 7'd0 : t + 7'd1;
      end else if (free) begin
        w_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: reference schedule model, handshake
// tracking, stall stability, back-to-back blocks and mid-block reset.
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_in;
  logic        first_in;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] w_out;
  logic [6:0]  w_round;
  logic        first_out;
  logic        w_valid;
  logic        w_ready;
  logic        block_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] msgs  [32];
  logic [31:0] exp_w [128];
  logic [31:0] got   [128];
  logic        firsts [2];

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .first_in(first_in),
    .word_valid(word_valid), .word_ready(word_ready), .w_out(w_out),
    .w_round(w_round), .first_out(first_out), .w_valid(w_valid),
    .w_ready(w_ready), .block_done(block_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ {10'b0, x[31:10]};
  endfunction

  task automatic build_model(input int nblk);
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 16; i++) exp_w[64*b+i] = msgs[16*b+i];
      for (int i = 16; i < 64; i++)
        exp_w[64*b+i] = s1(exp_w[64*b+i-2]) + exp_w[64*b+i-7]
                      + s0(exp_w[64*b+i-15]) + exp_w[64*b+i-16];
    end
  endtask

  task automatic load_abc(input int b, input logic f);
    for (int i = 0; i < 16; i++) msgs[16*b+i] = 32'h0;
    msgs[16*b]    = 32'h61626380;
    msgs[16*b+15] = 32'h00000018;
    firsts[b]     = f;
  endtask

  // Drives nblk blocks and checks every cycle; abort_at >= 0 pulses rst when that round appears.
  task automatic run(input int nblk, input int vld_pct, input int rdy_pct, input int abort_at);
    int acc = 0, ot = 0, issued63 = 0, cyc = 0;
    bit prev_hold = 0, exp_done = 0, started = 0, phase_load, accept, xfer, exp_rdy;
    logic [31:0] s_out;
    logic [6:0]  s_round;
    logic        s_first;
    word_valid = 1'b0;
    while (ot < 64*nblk && cyc < 4000) begin
      phase_load = (acc % 16 != 0) || (acc / 16 == issued63);
      if (acc < 16*nblk) begin
        if (!word_valid)
          word_valid = !phase_load || ($urandom_range(99) < vld_pct);
        word_in  = msgs[acc];
        first_in = (acc % 16 == 0) ? firsts[acc/16] : ~firsts[acc/16];
      end else begin
        word_valid = 1'b0;
      end
      w_ready = ($urandom_range(99) < rdy_pct);
      #1;
      n_cmp++;
      if (block_done !== exp_done) begin
        n_bad++; $display("FAIL block_done cyc=%0d got=%b want=%b", cyc, block_done, exp_done);
      end
      if (prev_hold) begin
        n_cmp++;
        if (w_valid !== 1'b1 || w_out !== s_out || w_round !== s_round || first_out !== s_first) begin
          n_bad++;
          $display("FAIL stall_hold cyc=%0d got v=%b %h/%0d/%b want 1 %h/%0d/%b",
                   cyc, w_valid, w_out, w_round, first_out, s_out, s_round, s_first);
        end
      end
      if (w_valid && !prev_hold && w_round == 7'd63) issued63++;
      exp_rdy = (!w_valid || w_ready) && ((acc % 16 != 0) || (acc / 16 == issued63));
      n_cmp++;
      if (word_ready !== exp_rdy) begin
        n_bad++; $display("FAIL word_ready cyc=%0d got=%b want=%b acc=%0d", cyc, word_ready, exp_rdy, acc);
      end
      if (w_valid) started = 1;
      if (vld_pct == 100 && rdy_pct == 100 && started) begin
        n_cmp++;
        if (w_valid !== 1'b1) begin
          n_bad++; $display("FAIL no_bubble cyc=%0d got w_valid=%b want 1", cyc, w_valid);
        end
      end
      if (abort_at >= 0 && w_valid && w_round == 7'(abort_at)) begin
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (w_valid !== 1'b0 || w_round !== 7'd0 || block_done !== 1'b0) begin
          n_bad++; $display("FAIL abort_reset got v=%b r=%0d d=%b want 0/0/0", w_valid, w_round, block_done);
        end
        rst = 1'b0;
        word_valid = 1'b0;
        break;
      end
      xfer = w_valid && w_ready;
      if (xfer) begin
        got[ot] = w_out;
        n_cmp++;
        if (w_out !== exp_w[ot] || w_round !== 7'(ot % 64) || first_out !== firsts[ot/64]) begin
          n_bad++;
          $display("FAIL word idx=%0d got %h/%0d/%b want %h/%0d/%b",
                   ot, w_out, w_round, first_out, exp_w[ot], ot % 64, firsts[ot/64]);
        end
        ot++;
      end
      exp_done  = xfer && (w_round == 7'd63);
      prev_hold = w_valid && !w_ready;
      s_out = w_out; s_round = w_round; s_first = first_out;
      accept = word_valid && word_ready;
      if (accept) acc++;
      @(posedge clk); #1;
      if (accept) word_valid = 1'b0;
      cyc++;
    end
    if (abort_at < 0) begin
      n_cmp++;
      if (ot != 64*nblk) begin
        n_bad++; $display("FAIL timeout got %0d words want %0d", ot, 64*nblk);
      end
      n_cmp++;
      if (block_done !== exp_done) begin
        n_bad++; $display("FAIL block_done_end got=%b want=%b", block_done, exp_done);
      end
    end
    word_valid = 1'b0;
    w_ready    = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; word_valid = 1'b1; word_in = 32'hdeadbeef; first_in = 1'b1; w_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (w_valid !== 1'b0 || w_out !== 32'h0 || w_round !== 7'd0 || first_out !== 1'b0 || block_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got v=%b out=%h r=%0d f=%b d=%b want all 0",
               w_valid, w_out, w_round, first_out, block_done);
    end
    rst = 1'b0; word_valid = 1'b0;
    #1;
    n_cmp++;
    if (word_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready got=%b want 1", word_ready);
    end
  endtask

  task automatic test_abc();
    load_abc(0, 1'b1);
    build_model(1);
    run(1, 100, 100, -1);
    n_cmp++;
    if (got[16] !== 32'h61626380) begin
      n_bad++; $display("FAIL abc_w16 got=%h want=61626380", got[16]);
    end
    n_cmp++;
    if (got[17] !== 32'h000F0000) begin
      n_bad++; $display("FAIL abc_w17 got=%h want=000f0000", got[17]);
    end
  endtask

  task automatic test_backpressure();
    load_abc(0, 1'b1);
    build_model(1);
    run(1, 100, 50, -1);
  endtask

  task automatic test_valid_gaps();
    load_abc(0, 1'b1);
    for (int i = 16; i < 32; i++) msgs[i] = $urandom;
    firsts[1] = 1'b0;
    build_model(2);
    run(2, 40, 100, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) msgs[i] = $urandom;
    firsts[0] = 1'b1;
    firsts[1] = 1'b0;
    build_model(2);
    run(2, 100, 100, -1);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 16; i++) msgs[i] = $urandom;
    firsts[0] = 1'b0;
    build_model(1);
    run(1, 100, 100, 40);
    test_abc();
  endtask

  initial begin
    rst = 1'b1; word_in = '0; first_in = 1'b0; word_valid = 1'b0; w_ready = 1'b1;
    test_reset();
    test_abc();
    test_backpressure();
    test_valid_gaps();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
